// File: rtl/dimmer_pkg.sv
// Shared types and constants for the LED dimmer control block.
package dimmer_pkg;

  localparam int unsigned DEFAULT_CNT_W = 19;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_e;

  // Quadrature AB codes in clockwise order.
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  // +1 for a CW quarter step, -1 for CCW, 0 for no change or a double-bit jump.
  function automatic logic signed [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      {AB_00, AB_01}, {AB_01, AB_11}, {AB_11, AB_10}, {AB_10, AB_00}: return 2'sd1;
      {AB_00, AB_10}, {AB_10, AB_11}, {AB_11, AB_01}, {AB_01, AB_00}: return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Rotary encoder front end: 2-flop synchronizer, transition decode and detent sub-count.
module quad_decoder
  import dimmer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ab,
  output logic       inc,
  output logic       dec
);

  logic [1:0]        sync1_q, sync2_q, prev_q;
  logic signed [2:0] sub_q, sub_d;
  logic              inc_q, inc_d, dec_q, dec_d;
  logic signed [1:0] step;

  always_comb begin
    step  = quad_step(prev_q, sync2_q);
    sub_d = sub_q;
    inc_d = 1'b0;
    dec_d = 1'b0;
    // A fourth quarter step in one direction completes a detent.
    if (step == 2'sd1) begin
      if (sub_q == 3'sd3) begin
        inc_d = 1'b1;
        sub_d = '0;
      end else begin
        sub_d = sub_q + 3'sd1;
      end
    end else if (step == -2'sd1) begin
      if (sub_q == -3'sd3) begin
        dec_d = 1'b1;
        sub_d = '0;
      end else begin
        sub_d = sub_q - 3'sd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      sub_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      sync1_q <= ab;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      sub_q   <= sub_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign inc = inc_q;
  assign dec = dec_q;

endmodule

// File: rtl/dimmer_ctrl.sv
// LED dimmer control: button debounce, ON/OFF FSM, brightness level and duty output.
// Define DIMMER_FADE_EN to ramp duty toward the target instead of following it directly.
module dimmer_ctrl
  import dimmer_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned MAX_DUTY    = 500000,
  parameter int unsigned DETENT_STEP = 25000,
  parameter int unsigned INIT_LEVEL  = 250000,
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned FADE_DIV    = 250,
  parameter int unsigned FADE_STEP   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       Encoder,
  input  logic             EncoderBoton,
  output logic [CNT_W-1:0] duty,
  output logic             on,
  output logic             busy
);

  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W:0] MAX_W  = (CNT_W + 1)'(MAX_DUTY);
  localparam logic [CNT_W:0] STEP_W = (CNT_W + 1)'(DETENT_STEP);

  logic inc, dec;

  quad_decoder u_quad_decoder (
    .clk (clk),
    .rst (rst),
    .ab  (Encoder),
    .inc (inc),
    .dec (dec)
  );

  // Button conditioning
  logic            btn_s1_q, btn_s2_q, db_q, db_d, press_q, press_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (btn_s2_q != db_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        db_d    = btn_s2_q;
        press_d = db_q & ~btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Control FSM and level
  state_e           state_q, state_d;
  logic [CNT_W-1:0] level_q, level_d, target;
  logic [CNT_W:0]   lvl_up, lvl_dn;

  assign lvl_up = {1'b0, level_q} + STEP_W;
  assign lvl_dn = {1'b0, level_q} - STEP_W;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      OFF: begin
        if (press_q) begin
          state_d = ON;
          if (level_q == '0) level_d = CNT_W'(DETENT_STEP);
        end
      end
      ON: begin
        // A press in the same cycle as a detent drops the detent.
        if (press_q) begin
          state_d = OFF;
        end else if (inc) begin
          level_d = (lvl_up > MAX_W) ? CNT_W'(MAX_DUTY) : lvl_up[CNT_W-1:0];
        end else if (dec) begin
          level_d = ({1'b0, level_q} < STEP_W) ? '0 : lvl_dn[CNT_W-1:0];
        end
      end
      default: ;
    endcase
  end

  assign target = (state_q == ON) ? level_q : '0;

  // Duty output
  logic [CNT_W-1:0] duty_q, duty_d;

`ifdef DIMMER_FADE_EN
  localparam int unsigned FD_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [CNT_W-1:0] FSTEP_W = CNT_W'(FADE_STEP);

  logic [FD_W-1:0] div_q, div_d;
  logic            fade_tick;

  assign fade_tick = (div_q == FD_W'(FADE_DIV - 1));

  always_comb begin
    div_d  = fade_tick ? '0 : div_q + FD_W'(1);
    duty_d = duty_q;
    if (fade_tick) begin
      if (duty_q < target) begin
        duty_d = ((target - duty_q) > FSTEP_W) ? duty_q + FSTEP_W : target;
      end else if (duty_q > target) begin
        duty_d = ((duty_q - target) > FSTEP_W) ? duty_q - FSTEP_W : target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  assign busy = (duty_q != target);
`else
  logic unused_fade_cfg;

  assign unused_fade_cfg = ^{32'(FADE_DIV), 32'(FADE_STEP)};
  assign duty_d          = target;
  assign busy            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
      db_q     <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
      state_q  <= OFF;
      level_q  <= CNT_W'(INIT_LEVEL);
      duty_q   <= '0;
    end else begin
      btn_s1_q <= EncoderBoton;
      btn_s2_q <= btn_s1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      state_q  <= state_d;
      level_q  <= level_d;
      duty_q   <= duty_d;
    end
  end

  assign duty = duty_q;
  assign on   = (state_q == ON);

endmodule

// File: tb/tb_dimmer_ctrl.sv
// Self-checking bench for dimmer_ctrl: cycle model compare plus directed and random stimulus.
module tb_dimmer_ctrl;

  localparam int unsigned CNT_W       = 19;
  localparam int unsigned MAX_DUTY    = 500000;
  localparam int unsigned DETENT_STEP = 25000;
  localparam int unsigned INIT_LEVEL  = 250000;
  localparam int unsigned DB_CYCLES   = 4;
  localparam int unsigned FADE_DIV    = 2;
  localparam int unsigned FADE_STEP   = 10000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       Encoder = 2'b00;
  logic             EncoderBoton = 1'b1;
  logic [CNT_W-1:0] duty;
  logic             on;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dimmer_ctrl #(
    .CNT_W       (CNT_W),
    .MAX_DUTY    (MAX_DUTY),
    .DETENT_STEP (DETENT_STEP),
    .INIT_LEVEL  (INIT_LEVEL),
    .DB_CYCLES   (DB_CYCLES),
    .FADE_DIV    (FADE_DIV),
    .FADE_STEP   (FADE_STEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Encoder      (Encoder),
    .EncoderBoton (EncoderBoton),
    .duty         (duty),
    .on           (on),
    .busy         (busy)
  );

  // Behavioural model: pin history, sub-count, debounce run length, on/level/duty.
  int         m_duty = 0, m_level = INIT_LEVEL, m_sub = 0, m_run = 0, m_cyc = 0;
  bit         m_on = 0, m_press = 0, m_inc = 0, m_dec = 0, m_db = 1, m_busy = 0;
  logic [1:0] h1 = 2'b00, h2 = 2'b00, h3 = 2'b00;
  logic       bh1 = 1'b1, bh2 = 1'b1;

  // Position of an AB code around the quadrature cycle.
  function automatic int gpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int d, tgt, n_sub;
    bit n_inc, n_dec, n_press;
    if (rst) begin
      m_duty = 0; m_level = INIT_LEVEL; m_sub = 0; m_run = 0; m_cyc = 0;
      m_on = 0; m_press = 0; m_inc = 0; m_dec = 0; m_db = 1;
      h1 = 2'b00; h2 = 2'b00; h3 = 2'b00; bh1 = 1'b1; bh2 = 1'b1;
    end else begin
      d = (gpos(h2) - gpos(h3) + 4) % 4;
      n_sub = m_sub; n_inc = 0; n_dec = 0;
      if (d == 1) begin
        n_sub = m_sub + 1;
        if (n_sub == 4) begin n_inc = 1; n_sub = 0; end
      end else if (d == 3) begin
        n_sub = m_sub - 1;
        if (n_sub == -4) begin n_dec = 1; n_sub = 0; end
      end
      h3 = h2; h2 = h1; h1 = Encoder;

      n_press = 0;
      if (bh2 == m_db) m_run = 0;
      else if (m_run == DB_CYCLES - 1) begin
        n_press = m_db & ~bh2;
        m_db = bh2;
        m_run = 0;
      end else m_run++;
      bh2 = bh1; bh1 = EncoderBoton;

      tgt = m_on ? m_level : 0;
`ifdef DIMMER_FADE_EN
      if ((m_cyc % FADE_DIV) == FADE_DIV - 1) begin
        if (m_duty < tgt) m_duty = (tgt - m_duty > FADE_STEP) ? m_duty + FADE_STEP : tgt;
        else if (m_duty > tgt) m_duty = (m_duty - tgt > FADE_STEP) ? m_duty - FADE_STEP : tgt;
      end
      m_cyc++;
`else
      m_duty = tgt;
`endif

      if (m_press) begin
        if (!m_on && m_level == 0) m_level = DETENT_STEP;
        m_on = !m_on;
      end else if (m_on && m_inc) begin
        m_level = (m_level + DETENT_STEP > MAX_DUTY) ? MAX_DUTY : m_level + DETENT_STEP;
      end else if (m_on && m_dec) begin
        m_level = (m_level < DETENT_STEP) ? 0 : m_level - DETENT_STEP;
      end
      m_press = n_press; m_inc = n_inc; m_dec = n_dec; m_sub = n_sub;
    end
`ifdef DIMMER_FADE_EN
    m_busy = (m_duty != (m_on ? m_level : 0));
`else
    m_busy = 0;
`endif
  end

  always @(negedge clk) begin
    checks++;
    if (duty !== CNT_W'(m_duty) || on !== m_on || busy !== m_busy) begin
      errors++;
      $display("FAIL cycle_model t=%0t: got duty=%0d on=%0b busy=%0b, expected duty=%0d on=%0b busy=%0b",
               $time, duty, on, busy, m_duty, m_on, m_busy);
    end
  end

  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         enc_pos = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic quarter(input int dir, input int hold);
    enc_pos = (enc_pos + dir + 4) % 4;
    Encoder = gray[enc_pos];
    tick(hold);
  endtask

  task automatic detents(input int dir, input int n);
    for (int i = 0; i < 4 * n; i++) quarter(dir, 2);
  endtask

  task automatic press_btn();
    EncoderBoton = 1'b0;
    tick(10);
    EncoderBoton = 1'b1;
    tick(10);
  endtask

  task automatic settle();
    int n;
    n = 0;
    tick(6);
    while (busy === 1'b1 && n < 500) begin
      tick(1);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL settle_timeout: got busy=%0b expected 0", busy);
    end
    tick(2);
  endtask

  initial begin
    rst = 1'b1;
    tick(3);
    chk("reset_duty", 32'(duty), 0);
    chk("reset_on", 32'(on), 0);
    chk("reset_busy", 32'(busy), 0);
    rst = 1'b0;

    EncoderBoton = 1'b0;
    tick(10);
    chk("first_press_on", 32'(on), 1);
`ifdef DIMMER_FADE_EN
    chk("ramp_busy", 32'(busy), 1);
`endif
    EncoderBoton = 1'b1;
    tick(10);
    settle();
    chk("on_duty_init", 32'(duty), 250000);

`ifdef DIMMER_FADE_EN
    EncoderBoton = 1'b0;
    tick(10);
    chk("ramp_down_off", 32'(on), 0);
    chk("ramp_down_busy", 32'(busy), 1);
    EncoderBoton = 1'b1;
    tick(10);
    EncoderBoton = 1'b0;
    tick(10);
    chk("redirect_on", 32'(on), 1);
    EncoderBoton = 1'b1;
    tick(10);
    settle();
    chk("redirect_duty", 32'(duty), 250000);
`endif

    detents(1, 1);
    settle();
    chk("cw_1", 32'(duty), 275000);

    detents(-1, 2);
    settle();
    chk("ccw_2", 32'(duty), 225000);

    for (int i = 0; i < 3; i++) quarter(1, 2);
    for (int i = 0; i < 3; i++) quarter(-1, 2);
    settle();
    chk("partial_reverse", 32'(duty), 225000);

    detents(1, 12);
    settle();
    chk("sat_max", 32'(duty), 500000);

    detents(-1, 30);
    settle();
    chk("sat_zero", 32'(duty), 0);
    chk("sat_zero_on", 32'(on), 1);

    press_btn();
    settle();
    chk("off_on", 32'(on), 0);
    press_btn();
    settle();
    chk("zero_level_press", 32'(duty), 25000);

    for (int i = 0; i < 5; i++) begin
      EncoderBoton = 1'b0;
      tick(2);
      EncoderBoton = 1'b1;
      tick(2);
    end
    settle();
    chk("bounce_on", 32'(on), 1);

    Encoder = 2'b11;
    tick(3);
    Encoder = 2'b00;
    tick(3);
    settle();
    chk("invalid_jump", 32'(duty), 25000);

    // Line the fourth quarter step up so inc lands in the same cycle as press.
    for (int i = 0; i < 3; i++) quarter(1, 2);
    EncoderBoton = 1'b0;
    tick(3);
    quarter(1, 10);
    EncoderBoton = 1'b1;
    tick(10);
    settle();
    chk("conflict_off", 32'(on), 0);
    press_btn();
    settle();
    chk("conflict_level", 32'(duty), 25000);

    press_btn();
    detents(1, 2);
    settle();
    chk("off_encoder_duty", 32'(duty), 0);
    press_btn();
    settle();
    chk("off_encoder_level", 32'(duty), 25000);

    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 12) begin
        quarter(($urandom_range(0, 2) == 0) ? -1 : 1, int'($urandom_range(1, 3)));
      end else if (r < 14) begin
        enc_pos = (enc_pos + 2) % 4;
        Encoder = gray[enc_pos];
        tick(2);
      end else if (r < 17) begin
        EncoderBoton = 1'b0;
        tick(int'($urandom_range(1, 7)));
        EncoderBoton = 1'b1;
        tick(int'($urandom_range(1, 8)));
      end else if (r < 19) begin
        EncoderBoton = 1'b0;
        tick(9);
        EncoderBoton = 1'b1;
        tick(9);
      end else begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
